// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the IF/ID/EX/MEM/WB pipeline.
// Optional performance counters are compiled in with `define PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int FLUSH_HOLD  = 2,
    parameter int STALL_LIMIT = 255
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [4:0]        stage_valid,
    input  logic              id_use_rj,
    input  logic              id_use_rk,
    input  logic [REG_AW-1:0] id_rj,
    input  logic [REG_AW-1:0] id_rk,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_div_busy,
    input  logic              mem_wait,
    input  logic              ex_br_taken,
    input  logic [31:0]       ex_br_target,
    input  logic              wb_exc,
    input  logic              wb_ertn,
    input  logic [31:0]       exc_entry,
    input  logic [31:0]       era,
    output logic [4:0]        ready_go,
    output logic [4:0]        flush,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    output logic              stall_timeout,
    output logic              dbg_fsm_state
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt,
    output logic [31:0]       perf_loaduse_cnt
`endif
);

    // Handshake: stage i hands its instruction on when stage_valid[i] & ready_go[i];
    // flush[i] discards the stage content regardless of ready_go.
    typedef enum logic {
        RUN       = 1'b0,
        EXC_FLUSH = 1'b1
    } state_t;

    localparam logic [3:0]  HOLD_INIT = 4'(FLUSH_HOLD - 1);
    localparam logic [15:0] WD_LIMIT  = 16'(STALL_LIMIT);

    state_t      state_q, state_d;
    logic [3:0]  hold_q, hold_d;
    logic [15:0] wd_q, wd_d;
    logic        stall_timeout_q, stall_timeout_d;

    logic        load_use;
    logic        stall_any;
    logic        wb_event;
    logic        br_fire;
    logic [4:0]  ready_go_c;
    logic [4:0]  flush_c;
    logic        redirect_valid_c;
    logic [31:0] redirect_pc_c;

    always_comb begin
        load_use = stage_valid[1] & stage_valid[2] & ex_is_load & (ex_rd != '0) &
                   ((id_use_rj & (id_rj == ex_rd)) | (id_use_rk & (id_rk == ex_rd)));

        ready_go_c    = 5'b11111;
        ready_go_c[1] = ~load_use;
        ready_go_c[2] = ~(stage_valid[2] & ex_div_busy);
        ready_go_c[3] = ~(stage_valid[3] & mem_wait);

        stall_any = |(stage_valid & ~ready_go_c);
        wb_event  = stage_valid[4] & (wb_exc | wb_ertn);
        br_fire   = stage_valid[2] & ex_br_taken & ready_go_c[2];

        state_d          = state_q;
        hold_d           = hold_q;
        flush_c          = 5'b00000;
        redirect_valid_c = 1'b0;
        redirect_pc_c    = 32'h0;

        case (state_q)
            RUN: begin
                // A WB event discards any same-cycle branch; the branch is flushed anyway.
                if (wb_event) begin
                    redirect_valid_c = 1'b1;
                    redirect_pc_c    = wb_exc ? exc_entry : era;
                    flush_c          = 5'b01111;
                    if (HOLD_INIT != 4'd0) begin
                        state_d = EXC_FLUSH;
                        hold_d  = HOLD_INIT;
                    end
                end else if (br_fire) begin
                    redirect_valid_c = 1'b1;
                    redirect_pc_c    = ex_br_target;
                    flush_c          = 5'b00011;
                end
            end
            EXC_FLUSH: begin
                flush_c = 5'b01111;
                if (hold_q <= 4'd1) begin
                    state_d = RUN;
                    hold_d  = 4'd0;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            default: begin
                state_d = RUN;
                hold_d  = 4'd0;
            end
        endcase

        if (!stall_any) begin
            wd_d = 16'd0;
        end else if (wd_q >= WD_LIMIT) begin
            wd_d = WD_LIMIT;
        end else begin
            wd_d = wd_q + 16'd1;
        end
        stall_timeout_d = stall_timeout_q | (wd_d == WD_LIMIT);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q         <= RUN;
            hold_q          <= 4'd0;
            wd_q            <= 16'd0;
            stall_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            hold_q          <= hold_d;
            wd_q            <= wd_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

    // Reset forces every stage to drop its content and let the pipe drain.
    assign ready_go       = aresetn ? ready_go_c       : 5'b11111;
    assign flush          = aresetn ? flush_c          : 5'b11111;
    assign redirect_valid = aresetn ? redirect_valid_c : 1'b0;
    assign redirect_pc    = aresetn ? redirect_pc_c    : 32'h0;
    assign stall_timeout  = stall_timeout_q;
    assign dbg_fsm_state  = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic [31:0] perf_loaduse_q, perf_loaduse_d;

    always_comb begin
        perf_stall_d   = perf_stall_q   + {31'd0, stall_any};
        perf_flush_d   = perf_flush_q   + {31'd0, redirect_valid_c};
        perf_loaduse_d = perf_loaduse_q + {31'd0, load_use};
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            perf_stall_q   <= 32'd0;
            perf_flush_q   <= 32'd0;
            perf_loaduse_q <= 32'd0;
        end else begin
            perf_stall_q   <= perf_stall_d;
            perf_flush_q   <= perf_flush_d;
            perf_loaduse_q <= perf_loaduse_d;
        end
    end

    assign perf_stall_cnt   = perf_stall_q;
    assign perf_flush_cnt   = perf_flush_q;
    assign perf_loaduse_cnt = perf_loaduse_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic against a cycle model.
module tb_pipe_hazard_ctrl;
  localparam int REG_AW      = 5;
  localparam int FLUSH_HOLD  = 2;
  localparam int STALL_LIMIT = 4;

  // clock / reset
  logic aclk;
  logic aresetn;
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  logic [4:0]        stage_valid;
  logic              id_use_rj, id_use_rk;
  logic [REG_AW-1:0] id_rj, id_rk, ex_rd;
  logic              ex_is_load, ex_div_busy, mem_wait, ex_br_taken;
  logic [31:0]       ex_br_target, exc_entry, era;
  logic              wb_exc, wb_ertn;
  logic [4:0]        ready_go, flush;
  logic              redirect_valid, stall_timeout, dbg_fsm_state;
  logic [31:0]       redirect_pc;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]       perf_stall_cnt, perf_flush_cnt, perf_loaduse_cnt;
`endif

  pipe_hazard_ctrl #(
    .REG_AW(REG_AW), .FLUSH_HOLD(FLUSH_HOLD), .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .stage_valid(stage_valid),
    .id_use_rj(id_use_rj), .id_use_rk(id_use_rk), .id_rj(id_rj), .id_rk(id_rk),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_div_busy(ex_div_busy),
    .mem_wait(mem_wait), .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
    .wb_exc(wb_exc), .wb_ertn(wb_ertn), .exc_entry(exc_entry), .era(era),
    .ready_go(ready_go), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall_timeout(stall_timeout),
    .dbg_fsm_state(dbg_fsm_state)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_loaduse_cnt(perf_loaduse_cnt)
`endif
  );

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  int m_hold_left = 0;
  int m_wd        = 0;
  bit m_to        = 1'b0;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] m_perf_stall = 0, m_perf_flush = 0, m_perf_lu = 0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_idle();
    aresetn = 1'b1; stage_valid = 5'b0;
    id_use_rj = 1'b0; id_use_rk = 1'b0; id_rj = '0; id_rk = '0;
    ex_is_load = 1'b0; ex_rd = '0; ex_div_busy = 1'b0; mem_wait = 1'b0;
    ex_br_taken = 1'b0; ex_br_target = 32'h0; wb_exc = 1'b0; wb_ertn = 1'b0;
    exc_entry = 32'h0; era = 32'h0;
  endtask

  task automatic set_random();
    aresetn      = ($urandom_range(0, 63) != 0);
    stage_valid  = 5'($urandom);
    id_use_rj    = 1'($urandom_range(0, 1));
    id_use_rk    = 1'($urandom_range(0, 1));
    id_rj        = REG_AW'($urandom_range(0, 3));
    id_rk        = REG_AW'($urandom_range(0, 3));
    ex_is_load   = 1'($urandom_range(0, 1));
    ex_rd        = REG_AW'($urandom_range(0, 3));
    ex_div_busy  = ($urandom_range(0, 3) == 0);
    mem_wait     = ($urandom_range(0, 3) == 0);
    ex_br_taken  = ($urandom_range(0, 3) == 0);
    ex_br_target = $urandom;
    wb_exc       = ($urandom_range(0, 7) == 0);
    wb_ertn      = ($urandom_range(0, 7) == 0);
    exc_entry    = $urandom;
    era          = $urandom;
  endtask

  // Called right after inputs change on a negedge; checks, advances the model, waits a cycle.
  task automatic step();
    logic [4:0]  e_rg, e_fl;
    logic        e_rv, lu, wbev, stall;
    logic [31:0] e_pc;
    #1;
    lu = stage_valid[1] && stage_valid[2] && ex_is_load && (ex_rd != 0) &&
         ((id_use_rj && id_rj == ex_rd) || (id_use_rk && id_rk == ex_rd));
    wbev = stage_valid[4] && (wb_exc || wb_ertn);
    e_rv = 1'b0; e_pc = 32'h0; e_fl = 5'b0; e_rg = 5'b11111;
    if (!aresetn) begin
      e_fl = 5'b11111;
    end else begin
      if (lu) e_rg[1] = 1'b0;
      if (stage_valid[2] && ex_div_busy) e_rg[2] = 1'b0;
      if (stage_valid[3] && mem_wait) e_rg[3] = 1'b0;
      if (m_hold_left > 0) begin
        e_fl = 5'b01111;
      end else if (wbev) begin
        e_fl = 5'b01111; e_rv = 1'b1; e_pc = wb_exc ? exc_entry : era;
      end else if (stage_valid[2] && ex_br_taken && e_rg[2]) begin
        e_fl = 5'b00011; e_rv = 1'b1; e_pc = ex_br_target;
      end
    end
    check("ready_go", 32'(ready_go), 32'(e_rg));
    check("flush", 32'(flush), 32'(e_fl));
    check("redirect_valid", 32'(redirect_valid), 32'(e_rv));
    check("stall_timeout", 32'(stall_timeout), 32'(m_to));
    check("fsm_state", 32'(dbg_fsm_state), 32'(m_hold_left > 0));
    if (!aresetn) check("redirect_pc_rst", redirect_pc, 32'h0);
    if (e_rv) exp_q.push_back(e_pc);
    if (redirect_valid) begin
      if (exp_q.size() == 0) check("redirect_spurious", 32'(redirect_valid), 32'd0);
      else check("redirect_pc", redirect_pc, exp_q.pop_front());
    end
`ifdef PIPE_CTRL_PERF_EN
    check("perf_stall", perf_stall_cnt, m_perf_stall);
    check("perf_flush", perf_flush_cnt, m_perf_flush);
    check("perf_loaduse", perf_loaduse_cnt, m_perf_lu);
`endif
    if (!aresetn) begin
      m_hold_left = 0; m_wd = 0; m_to = 1'b0;
`ifdef PIPE_CTRL_PERF_EN
      m_perf_stall = 0; m_perf_flush = 0; m_perf_lu = 0;
`endif
    end else begin
      stall = |(stage_valid & ~e_rg);
      if (m_hold_left > 0) m_hold_left--;
      else if (wbev) m_hold_left = FLUSH_HOLD - 1;
      m_wd = stall ? ((m_wd < STALL_LIMIT) ? m_wd + 1 : m_wd) : 0;
      if (m_wd == STALL_LIMIT) m_to = 1'b1;
`ifdef PIPE_CTRL_PERF_EN
      m_perf_stall = m_perf_stall + 32'(stall);
      m_perf_flush = m_perf_flush + 32'(e_rv);
      m_perf_lu    = m_perf_lu + 32'(lu);
`endif
    end
    @(negedge aclk);
  endtask

  initial begin
    set_idle();
    aresetn = 1'b0;
    @(negedge aclk);
    step();
    step();
    aresetn = 1'b1;
    step();

    // load-use
    set_idle();
    stage_valid = 5'b00110; ex_is_load = 1'b1; ex_rd = 5'd5; id_use_rj = 1'b1; id_rj = 5'd5;
    #1 check("loaduse_hit", 32'(ready_go), 32'(5'b11101));
    step();
    ex_rd = 5'd0; id_rj = 5'd0;
    #1 check("loaduse_r0", 32'(ready_go), 32'(5'b11111));
    step();

    // divider holds a taken branch until EX fires
    set_idle();
    stage_valid = 5'b00100; ex_div_busy = 1'b1; ex_br_taken = 1'b1; ex_br_target = 32'h1C001234;
    for (int i = 0; i < 3; i++) begin
      #1 check("div_no_redirect", 32'(redirect_valid), 32'd0);
      step();
    end
    ex_div_busy = 1'b0;
    #1 check("br_flush", 32'(flush), 32'(5'b00011));
    step();

    // exception
    set_idle();
    stage_valid = 5'b10000; wb_exc = 1'b1; exc_entry = 32'h1C008000;
    step();
    wb_exc = 1'b0;
    #1 check("exc_hold_flush", 32'(flush), 32'(5'b01111));
    step();
    #1 check("exc_flush_done", 32'(flush), 32'd0);
    step();

    // ertn and branch together: WB wins, branch is never redirected
    set_idle();
    stage_valid = 5'b10100; wb_ertn = 1'b1; era = 32'h1C000100;
    ex_br_taken = 1'b1; ex_br_target = 32'h1C00BEEF;
    #1 check("simul_pc", redirect_pc, 32'h1C000100);
    step();
    wb_ertn = 1'b0;
    step();
    set_idle();
    step();

    // watchdog
    set_idle();
    stage_valid = 5'b01000; mem_wait = 1'b1;
    for (int i = 0; i < 6; i++) step();
    mem_wait = 1'b0;
    #1 check("wd_sticky", 32'(stall_timeout), 32'd1);
    step();
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    #1 check("wd_cleared", 32'(stall_timeout), 32'd0);
    step();

    // reset during the first EXC_FLUSH cycle
    set_idle();
    stage_valid = 5'b10000; wb_exc = 1'b1; exc_entry = 32'h1C008000;
    step();
    wb_exc = 1'b0; aresetn = 1'b0;
    step();
    set_idle();
    #1 check("rst_mid_flush", 32'(flush), 32'd0);
    check("rst_mid_state", 32'(dbg_fsm_state), 32'd0);
    step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      set_random();
      step();
    end
    set_idle();
    step();
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
